// File: rtl/game_sequencer.sv
// Snake game flow controller: menu/init/play/pause/over sequencing, move timing,
// heading arbitration and growth bookkeeping for the snake datapath.
module game_sequencer #(
  parameter int FRAME_DIV      = 840000,
  parameter int STEPS_PER_MOVE = 3,
  parameter int MAX_SIZE       = 127
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic [4:0] dir_req,
  input  logic       good_collision,
  input  logic       bad_collision,
  output logic       inmenu,
  output logic       ingame,
  output logic       head_init,
  output logic       move_tick,
  output logic [1:0] cur_dir,
  output logic       grow,
  output logic [6:0] size,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int SW = (STEPS_PER_MOVE > 1) ? $clog2(STEPS_PER_MOVE) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [FW-1:0] FRAME_ZERO = FW'(0);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_MOVE - 1);
  localparam logic [SW-1:0] STEP_ONE   = SW'(1);
  localparam logic [SW-1:0] STEP_ZERO  = SW'(0);
  localparam logic [6:0]    SIZE_MAX   = 7'(MAX_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Maps a key request to {valid, heading}; anything not a single direction key is invalid.
  function automatic logic [2:0] decode_dir(input logic [4:0] req);
    logic [2:0] res;
    case (req)
      5'b00010: res = 3'b100;
      5'b00100: res = 3'b101;
      5'b01000: res = 3'b110;
      5'b10000: res = 3'b111;
      default:  res = 3'b000;
    endcase
    return res;
  endfunction

  state_t        state_r;
  state_t        state_s;
  logic          start_q_r;
  logic          good_q_r;
  logic [FW-1:0] frame_cnt_r;
  logic [SW-1:0] step_cnt_r;
  logic          dir_lock_r;
  logic          grow_lock_r;
  logic [1:0]    cur_dir_r;
  logic [6:0]    size_r;
  logic          head_init_r;
  logic          move_tick_r;
  logic          grow_r;

  logic          start_edge_s;
  logic          active_s;
  logic          frame_tick_s;
  logic          move_s;
  logic          grow_s;
  logic          dir_ok_s;
  logic [2:0]    dir_dec_s;

  // Play-cycle qualifiers: bad collision or pause freeze everything in that cycle.
  always_comb begin
    start_edge_s = start & ~start_q_r;
    active_s     = (state_r == ST_PLAY) & ~pause & ~bad_collision;
    frame_tick_s = active_s & (frame_cnt_r == FRAME_ZERO);
    move_s       = frame_tick_s & (step_cnt_r == STEP_LAST);
    dir_dec_s    = decode_dir(dir_req);
    // Equal or opposite headings share bit 0 with the current heading.
    dir_ok_s     = active_s & dir_dec_s[2] & ~dir_lock_r & (dir_dec_s[0] != cur_dir_r[0]);
    grow_s       = active_s & good_collision & ~good_q_r & ~grow_lock_r;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) state_s = ST_INIT;
        else              state_s = ST_IDLE;
      end
      ST_INIT: state_s = ST_PLAY;
      ST_PLAY: begin
        if (bad_collision) state_s = ST_OVER;
        else if (pause)    state_s = ST_PAUSE;
        else               state_s = ST_PLAY;
      end
      ST_PAUSE: begin
        if (pause) state_s = ST_PAUSE;
        else       state_s = ST_PLAY;
      end
      ST_OVER: begin
        if (start_edge_s) state_s = ST_INIT;
        else              state_s = ST_OVER;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Edge history, timing counters, heading, length and locks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q_r   <= 1'b1;
      good_q_r    <= 1'b0;
      frame_cnt_r <= FRAME_ZERO;
      step_cnt_r  <= STEP_ZERO;
      dir_lock_r  <= 1'b0;
      grow_lock_r <= 1'b0;
      cur_dir_r   <= 2'd3;
      size_r      <= 7'd1;
    end else begin
      start_q_r <= start;
      good_q_r  <= good_collision;
      if (state_s == ST_INIT) begin
        // Preloading the frame count puts the first move a full move period after play starts.
        frame_cnt_r <= FRAME_LAST;
        step_cnt_r  <= STEP_ZERO;
        dir_lock_r  <= 1'b0;
        grow_lock_r <= 1'b0;
        cur_dir_r   <= 2'd3;
        size_r      <= 7'd1;
      end else if (active_s) begin
        if (frame_tick_s) begin
          frame_cnt_r <= FRAME_LAST;
          step_cnt_r  <= move_s ? STEP_ZERO : (step_cnt_r + STEP_ONE);
        end else begin
          frame_cnt_r <= frame_cnt_r - FRAME_ONE;
        end
        if (dir_ok_s) cur_dir_r <= dir_dec_s[1:0];
        if (grow_s && (size_r < SIZE_MAX)) size_r <= size_r + 7'd1;
        if (move_s) begin
          dir_lock_r  <= 1'b0;
          grow_lock_r <= 1'b0;
        end else begin
          if (dir_ok_s) dir_lock_r  <= 1'b1;
          if (grow_s)   grow_lock_r <= 1'b1;
        end
      end
    end
  end

  // One-cycle output strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_init_r <= 1'b0;
      move_tick_r <= 1'b0;
      grow_r      <= 1'b0;
    end else begin
      head_init_r <= (state_s == ST_INIT);
      move_tick_r <= move_s;
      grow_r      <= grow_s;
    end
  end

  assign inmenu    = (state_r == ST_IDLE);
  assign ingame    = (state_r == ST_PLAY) | (state_r == ST_PAUSE);
  assign game_over = (state_r == ST_OVER);
  assign state     = state_r;
  assign head_init = head_init_r;
  assign move_tick = move_tick_r;
  assign grow      = grow_r;
  assign cur_dir   = cur_dir_r;
  assign size      = size_r;

endmodule
